// File: rtl/fp_mul_seq.sv
// fp_mul_seq: IEEE-754-style multiplier, shift-add mantissa datapath, flush-to-zero, four rounding modes.
// Latency: done_sig MAN_W+4 edges after capture for normal operands, 2 edges for special operands.
// Backpressure: none; start_sig sampled only in IDLE, result/flags held until the next DONE entry.
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_sig,
    input  logic [1:0]           rnd_mode,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 done_sig,
    output logic                 busy,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;        // mantissa width incl. hidden bit
    localparam int PW = 2 * M;            // full product width
    localparam int XW = EXP_W + 2;        // signed working exponent width
    localparam int CW = $clog2(M + 1);

    localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EZERO = '0;
    localparam logic signed [XW-1:0] EONE  = XW'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

    state_t                state;
    logic [W-1:0]          a_r, b_r;
    logic [1:0]            mode_r;
    logic                  sign_r;
    logic signed [XW-1:0]  exp_r;
    logic [M-1:0]          ma_r;
    logic [PW-1:0]         prod_r;
    logic [CW-1:0]         cnt_r;
    logic [M-1:0]          man_r;
    logic                  g_r, r_r, s_r;
    logic                  spec_r;
    logic [W-1:0]          spec_res_r;
    logic [3:0]            spec_flg_r;

    // Operand classification on the captured words
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sign_c;
    logic signed [XW-1:0] exp_sum_c;

    assign ea        = a_r[W-2:MAN_W];
    assign eb        = b_r[W-2:MAN_W];
    assign fa        = a_r[MAN_W-1:0];
    assign fb        = b_r[MAN_W-1:0];
    assign a_nan     = (&ea) & (|fa);
    assign b_nan     = (&eb) & (|fb);
    assign a_snan    = a_nan & ~fa[MAN_W-1];
    assign b_snan    = b_nan & ~fb[MAN_W-1];
    assign a_inf     = (&ea) & ~(|fa);
    assign b_inf     = (&eb) & ~(|fb);
    assign a_zero    = ~(|ea);             // subnormals flush to zero
    assign b_zero    = ~(|eb);
    assign sign_c    = a_r[W-1] ^ b_r[W-1];
    assign exp_sum_c = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    // Special-value result selection; NaN beats Inf*0 beats Inf beats zero
    logic         spec_c;
    logic [W-1:0] spec_res_c;
    logic [3:0]   spec_flg_c;
    always_comb begin
        spec_c     = 1'b1;
        spec_res_c = QNAN;
        spec_flg_c = 4'b0000;
        if (a_nan | b_nan) begin
            spec_flg_c = {a_snan | b_snan, 3'b000};
        end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
            spec_flg_c = 4'b1000;
        end else if (a_inf | b_inf) begin
            spec_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero | b_zero) begin
            spec_res_c = {sign_c, {(W-1){1'b0}}};
        end else begin
            spec_c = 1'b0;
        end
    end

    // One shift-add step: add multiplicand into the upper half when the current multiplier bit is set
    logic [M:0] mac_sum;
    assign mac_sum = {1'b0, prod_r[PW-1:M]} + (prod_r[0] ? {1'b0, ma_r} : {(M+1){1'b0}});

    // Rounding, renormalisation on carry-out, and overflow/underflow result selection
    logic                 inx, inc, ovf, unf, to_inf;
    logic [M:0]           man_inc;
    logic [MAN_W-1:0]     frac_fin;
    logic signed [XW-1:0] exp_fin;
    logic [W-1:0]         rnd_res;
    logic [3:0]           rnd_flg;
    always_comb begin
        inx = g_r | r_r | s_r;
        case (mode_r)
            2'b00:   inc = g_r & (r_r | s_r | man_r[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~sign_r & inx;
            default: inc = sign_r & inx;
        endcase
        man_inc  = {1'b0, man_r} + {{M{1'b0}}, inc};
        frac_fin = man_inc[MAN_W-1:0];
        exp_fin  = exp_r;
        if (man_inc[M]) begin
            frac_fin = man_inc[MAN_W:1];
            exp_fin  = exp_r + EONE;
        end
        ovf    = (exp_fin >= EMAX);
        unf    = (exp_fin <= EZERO);
        to_inf = (mode_r == 2'b00) | ((mode_r == 2'b10) & ~sign_r) | ((mode_r == 2'b11) & sign_r);
        rnd_res = {sign_r, exp_fin[EXP_W-1:0], frac_fin};
        rnd_flg = {3'b000, inx};
        if (ovf) begin
            rnd_res = to_inf ? {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {sign_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            rnd_flg = 4'b0101;
        end else if (unf) begin
            rnd_res = {sign_r, {(W-1){1'b0}}};
            rnd_flg = 4'b0011;
        end
    end

    // Control FSM and datapath registers; result/flags only update on the way into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            mode_r     <= '0;
            sign_r     <= 1'b0;
            exp_r      <= '0;
            ma_r       <= '0;
            prod_r     <= '0;
            cnt_r      <= '0;
            man_r      <= '0;
            g_r        <= 1'b0;
            r_r        <= 1'b0;
            s_r        <= 1'b0;
            spec_r     <= 1'b0;
            spec_res_r <= '0;
            spec_flg_r <= '0;
            result     <= '0;
            flags      <= '0;
            done_sig   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_sig) begin
                        a_r    <= A;
                        b_r    <= B;
                        mode_r <= rnd_mode;
                        busy   <= 1'b1;
                        state  <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_r     <= sign_c;
                    exp_r      <= exp_sum_c;
                    ma_r       <= {1'b1, fa};
                    prod_r     <= {{M{1'b0}}, 1'b1, fb};
                    cnt_r      <= '0;
                    spec_r     <= spec_c;
                    spec_res_r <= spec_res_c;
                    spec_flg_r <= spec_flg_c;
                    state      <= spec_c ? ROUND : MULT;
                end
                MULT: begin
                    prod_r <= {mac_sum, prod_r[M-1:1]};
                    cnt_r  <= cnt_r + CW'(1);
                    if (cnt_r == CW'(M - 1)) state <= NORM;
                end
                NORM: begin
                    if (prod_r[PW-1]) begin
                        man_r <= prod_r[PW-1:M];
                        g_r   <= prod_r[M-1];
                        r_r   <= prod_r[M-2];
                        s_r   <= |prod_r[M-3:0];
                        exp_r <= exp_r + EONE;
                    end else begin
                        man_r <= prod_r[PW-2:M-1];
                        g_r   <= prod_r[M-2];
                        r_r   <= prod_r[M-3];
                        s_r   <= |prod_r[M-4:0];
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    result   <= spec_r ? spec_res_r : rnd_res;
                    flags    <= spec_r ? spec_flg_r : rnd_flg;
                    done_sig <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_sig <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed vectors for single-precision and half-precision fp_mul_seq instances.
// Latency: checks done_sig edge count against capture edge for each operation.
// Backpressure: controller holds start_sig until done_sig, then drops it.
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        done, busy;

    logic        hstart = 1'b0;
    logic [1:0]  hmode = 2'b00;
    logic [15:0] ha = '0, hb = '0;
    logic [15:0] hresult;
    logic [3:0]  hflags;
    logic        hdone, hbusy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .start_sig(start), .rnd_mode(mode),
        .A(a), .B(b), .result(result), .done_sig(done), .busy(busy), .flags(flags)
    );

    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst_n(rst_n), .start_sig(hstart), .rnd_mode(hmode),
        .A(ha), .B(hb), .result(hresult), .done_sig(hdone), .busy(hbusy), .flags(hflags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  m;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  m;
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
    } hvec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Waits for idle, captures one operation, returns result, flags and done latency in edges
    task automatic run_main(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] tm,
                            output logic [31:0] r, output logic [3:0] f, output int lat);
        int g;
        g = 0;
        while (busy && g < 100) begin @(posedge clk); #1; g++; end
        a = ta; b = tb_v; mode = tm; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!done && lat < 200);
        start = 1'b0;
        r = result; f = flags;
    endtask

    task automatic run_half(input logic [15:0] ta, input logic [15:0] tb_v, input logic [1:0] tm,
                            output logic [15:0] r, output logic [3:0] f, output int lat);
        int g;
        g = 0;
        while (hbusy && g < 100) begin @(posedge clk); #1; g++; end
        ha = ta; hb = tb_v; hmode = tm; hstart = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!hdone && lat < 200);
        hstart = 1'b0;
        r = hresult; f = hflags;
    endtask

    vec_t  vt[20];
    hvec_t ht[3];

    initial begin
        logic [31:0] r;
        logic [15:0] hr;
        logic [3:0]  f;
        int          lat;
        int          n;
        int          seen;

        vt[0]  = '{32'h40200000, 32'h40A00000, 2'd0, 32'h41480000, 4'b0000, 27};
        vt[1]  = '{32'hC0000000, 32'h40400000, 2'd0, 32'hC0C00000, 4'b0000, 27};
        vt[2]  = '{32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001, 27};
        vt[3]  = '{32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0001, 27};
        vt[4]  = '{32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'b0001, 27};
        vt[5]  = '{32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'b1000, 2};
        vt[6]  = '{32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 4'b0000, 2};
        vt[7]  = '{32'h00400000, 32'h40000000, 2'd0, 32'h00000000, 4'b0000, 2};
        vt[8]  = '{32'h7F000000, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101, 27};
        vt[9]  = '{32'h7F000000, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101, 27};
        vt[10] = '{32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 4'b0011, 27};
        vt[11] = '{32'h7FA00000, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b1000, 2};
        vt[12] = '{32'h7FC00001, 32'h40000000, 2'd0, 32'h7FC00000, 4'b0000, 2};
        vt[13] = '{32'h7F800000, 32'hFF800000, 2'd0, 32'hFF800000, 4'b0000, 2};
        vt[14] = '{32'hFF000000, 32'h40000000, 2'd3, 32'hFF800000, 4'b0101, 27};
        vt[15] = '{32'hFF000000, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'b0101, 27};
        vt[16] = '{32'h3F800001, 32'h3FC00000, 2'd0, 32'h3FC00002, 4'b0001, 27};
        vt[17] = '{32'h3F800003, 32'h3FC00000, 2'd0, 32'h3FC00004, 4'b0001, 27};
        vt[18] = '{32'h3FFFFFFE, 32'h3F800001, 2'd0, 32'h40000000, 4'b0001, 27};
        vt[19] = '{32'h3FFFFFFE, 32'h3F800001, 2'd1, 32'h3FFFFFFF, 4'b0001, 27};

        ht[0] = '{16'h3C00, 16'h4000, 2'd0, 16'h4000, 4'b0000, 14};
        ht[1] = '{16'h7BFF, 16'h4000, 2'd0, 16'h7C00, 4'b0101, 14};
        ht[2] = '{16'hC000, 16'h4200, 2'd0, 16'hC600, 4'b0000, 14};

        // Reset state
        #12;
        chk("reset_result", result, 32'h0);
        chk("reset_flags", {28'h0, flags}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Main table
        for (int i = 0; i < 20; i++) begin
            run_main(vt[i].a, vt[i].b, vt[i].m, r, f, lat);
            chk($sformatf("v%0d_result", i), r, vt[i].res);
            chk($sformatf("v%0d_flags", i), {28'h0, f}, {28'h0, vt[i].flg});
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d_busy_at_done", i), {31'h0, busy}, 32'h1);
        end

        // Result and flags hold after the operation completes
        repeat (4) @(posedge clk);
        #1;
        chk("hold_result", result, 32'h3FFFFFFF);
        chk("hold_flags", {28'h0, flags}, 32'h1);
        chk("hold_busy", {31'h0, busy}, 32'h0);

        // Half-precision instance
        for (int i = 0; i < 3; i++) begin
            run_half(ht[i].a, ht[i].b, ht[i].m, hr, f, lat);
            chk($sformatf("h%0d_result", i), {16'h0, hr}, {16'h0, ht[i].res});
            chk($sformatf("h%0d_flags", i), {28'h0, f}, {28'h0, ht[i].flg});
            chk($sformatf("h%0d_latency", i), lat, ht[i].lat);
        end

        // Reset at edge 10 of a multiply aborts it
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        a = 32'h40200000; b = 32'h40A00000; mode = 2'd0; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_result", result, 32'h0);
        chk("abort_flags", {28'h0, flags}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        run_main(32'h40200000, 32'h40A00000, 2'd0, r, f, lat);
        chk("post_reset_result", r, 32'h41480000);
        chk("post_reset_latency", lat, 27);

        // Back-to-back: start_sig held through DONE
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        a = 32'h40200000; b = 32'h40A00000; mode = 2'd0; start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!done && n < 200);
        chk("b2b_first_latency", n, 27);
        chk("b2b_first_result", result, 32'h41480000);
        a = 32'hC0000000; b = 32'h40400000;
        @(posedge clk); #1;
        n++;
        chk("b2b_done_pulse", {31'h0, done}, 32'h0);
        chk("b2b_idle_bubble", {31'h0, busy}, 32'h0);
        do begin @(posedge clk); #1; n++; end while (!done && n < 300);
        start = 1'b0;
        chk("b2b_second_latency", n, 56);
        chk("b2b_second_result", result, 32'hC0C00000);
        chk("b2b_second_flags", {28'h0, flags}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
